// File: rtl/updown_phase_ctrl.sv
// updown_phase_ctrl: sequences enable_up / enable_down for the 3-bit up/down counter pair.
// Each start request runs NUM_ROUNDS rounds. A round is an UP phase of PHASE_LEN clocks
// followed by a DOWN phase of PHASE_LEN clocks. stop aborts the sequence back to IDLE.
// Optional feature macro: PHASE_GAP_EN inserts a one-clock GAP state (both enables low)
// between every UP->DOWN and DOWN->UP transition, so the counters get a settle cycle.
// All outputs are registered and decoded from the next state, so they change on the
// same edge as the state register.
module updown_phase_ctrl #(
  parameter int unsigned PHASE_LEN  = 8,
  parameter int unsigned NUM_ROUNDS = 1,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned RND_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  output logic enable_up,
  output logic enable_down,
  output logic phase_switch,
  output logic busy,
  output logic done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StUp   = 2'd1;
  localparam logic [1:0] StDown = 2'd2;
`ifdef PHASE_GAP_EN
  localparam logic [1:0] StGap  = 2'd3;
`endif

  // Terminal counts; the legal parameter ranges guarantee these fit the counter widths.
  localparam logic [CNT_W-1:0] PhaseLast = CNT_W'(PHASE_LEN - 1);
  localparam logic [RND_W-1:0] RoundLast = RND_W'(NUM_ROUNDS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [RND_W-1:0] round_cnt_q, round_cnt_d;
  logic             enable_up_q, enable_down_q, phase_switch_q, busy_q, done_q;
  logic             done_d;
  logic             phase_end, round_end;
`ifdef PHASE_GAP_EN
  // Remembers which phase follows the current GAP.
  logic             gap_to_down_q, gap_to_down_d;
`endif

  assign phase_end = (phase_cnt_q == PhaseLast);
  assign round_end = (round_cnt_q == RoundLast);

  // Next-state, counter and done-pulse logic.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    round_cnt_d = round_cnt_q;
    done_d      = 1'b0;
`ifdef PHASE_GAP_EN
    gap_to_down_d = gap_to_down_q;
`endif
    if ((state_q != StIdle) && stop) begin
      // Abort: no done pulse, counters cleared.
      state_d     = StIdle;
      phase_cnt_d = '0;
      round_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          phase_cnt_d = '0;
          round_cnt_d = '0;
          if (start && !stop) begin
            state_d = StUp;
          end
        end
        StUp: begin
          if (phase_end) begin
            phase_cnt_d = '0;
`ifdef PHASE_GAP_EN
            state_d       = StGap;
            gap_to_down_d = 1'b1;
`else
            state_d       = StDown;
`endif
          end else begin
            phase_cnt_d = phase_cnt_q + CNT_W'(1);
          end
        end
        StDown: begin
          if (phase_end) begin
            phase_cnt_d = '0;
            if (round_end) begin
              // The last DOWN phase goes straight to IDLE, even with the gap enabled.
              state_d     = StIdle;
              round_cnt_d = '0;
              done_d      = 1'b1;
            end else begin
              round_cnt_d = round_cnt_q + RND_W'(1);
`ifdef PHASE_GAP_EN
              state_d       = StGap;
              gap_to_down_d = 1'b0;
`else
              state_d       = StUp;
`endif
            end
          end else begin
            phase_cnt_d = phase_cnt_q + CNT_W'(1);
          end
        end
`ifdef PHASE_GAP_EN
        StGap: begin
          state_d = gap_to_down_q ? StDown : StUp;
        end
`endif
        default: begin
          state_d     = StIdle;
          phase_cnt_d = '0;
          round_cnt_d = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_cnt_q <= '0;
      round_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      round_cnt_q <= round_cnt_d;
    end
  end

`ifdef PHASE_GAP_EN
  // Gap direction flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_to_down_q <= 1'b0;
    end else begin
      gap_to_down_q <= gap_to_down_d;
    end
  end
`endif

  // Output registers decoded from the next state; phase_switch marks entry into DOWN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_up_q    <= 1'b0;
      enable_down_q  <= 1'b0;
      phase_switch_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      enable_up_q    <= (state_d == StUp);
      enable_down_q  <= (state_d == StDown);
      phase_switch_q <= (state_d == StDown) && (state_q != StDown);
      busy_q         <= (state_d != StIdle);
      done_q         <= done_d;
    end
  end

  assign enable_up    = enable_up_q;
  assign enable_down  = enable_down_q;
  assign phase_switch = phase_switch_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
